// File: rtl/byte_word_bridge_pkg.sv
// Shared definitions for the byte<->word bridge: FSM encoding and the
// byte-index to byte-lane mapping used by both the pack and unpack paths.
package byte_word_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_COMMIT,
    RD_FETCH,
    RD_WAIT,
    RD_SEND,
    FINISH
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int lane_of(input int byte_idx, input int word_bytes, input bit big_endian);
    int n;
    n = byte_idx % word_bytes;
    return big_endian ? (word_bytes - 1 - n) : n;
  endfunction

endpackage

// File: rtl/byte_word_bridge_if.sv
// Control, byte-stream and word-memory signals of the bridge.
// master = the bridge itself, slave = host/UART side plus the RAM.
interface byte_word_bridge_if
  import byte_word_bridge_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 6,
  parameter int WORD_BYTES      = 4
) ();
  localparam int LANE_W          = clog2(WORD_BYTES);
  localparam int WORD_ADDR_WIDTH = BYTE_ADDR_WIDTH - LANE_W;

  logic                         start;
  logic                         mode;
  logic [WORD_ADDR_WIDTH-1:0]   start_word;
  logic [BYTE_ADDR_WIDTH:0]     byte_count;
  logic                         busy;
  logic                         done;
  logic [7:0]                   in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [7:0]                   out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [WORD_ADDR_WIDTH-1:0]   mem_addr;
  logic                         mem_we;
  logic [WORD_BYTES-1:0]        mem_be;
  logic [8*WORD_BYTES-1:0]      mem_wdata;
  logic [8*WORD_BYTES-1:0]      mem_rdata;

  modport master (
    input  start, mode, start_word, byte_count, in_data, in_valid, out_ready, mem_rdata,
    output busy, done, in_ready, out_data, out_valid, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport slave (
    output start, mode, start_word, byte_count, in_data, in_valid, out_ready, mem_rdata,
    input  busy, done, in_ready, out_data, out_valid, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/byte_word_bridge_lane_mux.sv
// Combinational byte-lane access: extracts one lane of a word and produces
// the same word with that lane replaced by a new byte.
module byte_lane_mux
  import byte_word_bridge_pkg::*;
#(
  parameter  int WORD_BYTES = 4,
  localparam int LANE_W     = clog2(WORD_BYTES)
) (
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic [LANE_W-1:0]       lane,
  input  logic [7:0]              byte_in,
  output logic [7:0]              byte_out,
  output logic [8*WORD_BYTES-1:0] word_out
);

  always_comb begin
    word_out = word_in;
    byte_out = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == LANE_W'(i)) begin
        byte_out            = word_in[8*i +: 8];
        word_out[8*i +: 8]  = byte_in;
      end
    end
  end

endmodule

// File: rtl/byte_word_bridge.sv
// Sequential byte<->word bridge: packs a byte stream into byte-enabled word
// writes, or fetches words and serialises them back into bytes.
module byte_word_bridge
  import byte_word_bridge_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 6,
  parameter int WORD_BYTES      = 4,
  parameter bit BIG_ENDIAN      = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  byte_word_bridge_if.master bus
);

  localparam int LANE_W          = clog2(WORD_BYTES);
  localparam int WORD_ADDR_WIDTH = BYTE_ADDR_WIDTH - LANE_W;
  localparam int WORD_W          = 8 * WORD_BYTES;
  localparam int CNT_W           = BYTE_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  MAX_BYTES = {1'b1, {BYTE_ADDR_WIDTH{1'b0}}};
  localparam logic [LANE_W-1:0] LAST_IDX  = LANE_W'(WORD_BYTES - 1);

  state_t                     state_q, state_d;
  logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]           rem_q, rem_d;
  logic [LANE_W-1:0]          idx_q, idx_d;
  logic [WORD_W-1:0]          buf_q, buf_d;
  logic [WORD_BYTES-1:0]      be_q, be_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [7:0]                 out_data_q, out_data_d;
  logic                       mem_we_q, mem_we_d;
  logic [WORD_BYTES-1:0]      mem_be_q, mem_be_d;
  logic [WORD_W-1:0]          mem_wdata_q, mem_wdata_d;

  logic [CNT_W-1:0]           cnt_in;
  logic [WORD_W-1:0]          mux_word;
  logic [LANE_W-1:0]          mux_idx;
  logic [LANE_W-1:0]          mux_lane;
  logic [7:0]                 mux_byte;
  logic [WORD_W-1:0]          mux_word_ins;

  assign cnt_in = (bus.byte_count > MAX_BYTES) ? MAX_BYTES : bus.byte_count;

  // Write and read never overlap, so one lane mux serves both directions:
  // in RD_WAIT it looks at the fresh RAM word, in RD_SEND one byte ahead.
  always_comb begin
    mux_word = buf_q;
    mux_idx  = idx_q;
    if (state_q == RD_WAIT) begin
      mux_word = bus.mem_rdata;
      mux_idx  = '0;
    end else if (state_q == RD_SEND) begin
      mux_idx  = idx_q + 1'b1;
    end
    mux_lane = LANE_W'(lane_of(int'(mux_idx), WORD_BYTES, BIG_ENDIAN));
  end

  byte_lane_mux #(
    .WORD_BYTES (WORD_BYTES)
  ) u_lane_mux (
    .word_in  (mux_word),
    .lane     (mux_lane),
    .byte_in  (bus.in_data),
    .byte_out (mux_byte),
    .word_out (mux_word_ins)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    be_d        = be_q;
    out_data_d  = out_data_q;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d = bus.start_word;
          rem_d  = cnt_in;
          idx_d  = '0;
          buf_d  = '0;
          be_d   = '0;
          if (cnt_in == '0) state_d = FINISH;
          else              state_d = bus.mode ? RD_FETCH : WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        if (bus.in_valid && in_ready_q) begin
          buf_d = mux_word_ins;
          be_d  = be_q | (WORD_BYTES'(1) << mux_lane);
          rem_d = rem_q - 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX || rem_q == CNT_W'(1)) begin
            state_d     = WR_COMMIT;
            mem_we_d    = 1'b1;
            mem_be_d    = be_d;
            mem_wdata_d = buf_d;
          end
        end
      end
      WR_COMMIT: begin
        buf_d       = '0;
        be_d        = '0;
        idx_d       = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        addr_d      = addr_q + 1'b1;
        state_d     = (rem_q != '0) ? WR_COLLECT : FINISH;
      end
      RD_FETCH: state_d = RD_WAIT;
      RD_WAIT: begin
        buf_d      = bus.mem_rdata;
        out_data_d = mux_byte;
        state_d    = RD_SEND;
      end
      RD_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          rem_d = rem_q - 1'b1;
          idx_d = idx_q + 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = FINISH;
          end else if (idx_q == LAST_IDX) begin
            addr_d  = addr_q + 1'b1;
            state_d = RD_FETCH;
          end else begin
            out_data_d = mux_byte;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    in_ready_d  = (state_d == WR_COLLECT);
    out_valid_d = (state_d == RD_SEND);
    if (state_d != RD_SEND) out_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      be_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      be_q        <= be_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_byte_word_bridge.sv
// Bench for byte_word_bridge: a little-endian and a big-endian instance run
// the same stimulus side by side against one memory model per instance.
module tb_byte_word_bridge;

  typedef struct packed {
    logic [3:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       start, mode;
  logic [3:0] start_word;
  logic [6:0] byte_count;
  logic [7:0] in_data;
  logic       in_valid, out_ready;

  logic        bd_we;
  logic [3:0]  bd_a;
  logic [31:0] bd_d;
  logic [31:0] ram_le [16];
  logic [31:0] ram_be [16];
  logic [31:0] mdl_le [16];
  logic [31:0] mdl_be [16];

  wr_t        wr_le[$], wr_be[$];
  logic [7:0] rd_le[$], rd_be[$];
  logic [7:0] tx_bytes[$];
  int  done_le, done_be, viol_le, viol_be;
  int  cyc, start_cyc, first_ov;
  bit  cur_mode, gaps;
  bit  prev_stall_le, prev_stall_be;
  logic [7:0] prev_data_le, prev_data_be;
  int  n_checks, n_pass;

  byte_word_bridge_if #(.BYTE_ADDR_WIDTH(6), .WORD_BYTES(4)) if_le ();
  byte_word_bridge_if #(.BYTE_ADDR_WIDTH(6), .WORD_BYTES(4)) if_be ();

  byte_word_bridge #(.BYTE_ADDR_WIDTH(6), .WORD_BYTES(4), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .bus(if_le)
  );
  byte_word_bridge #(.BYTE_ADDR_WIDTH(6), .WORD_BYTES(4), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .bus(if_be)
  );

  assign if_le.start = start;           assign if_be.start = start;
  assign if_le.mode = mode;             assign if_be.mode = mode;
  assign if_le.start_word = start_word; assign if_be.start_word = start_word;
  assign if_le.byte_count = byte_count; assign if_be.byte_count = byte_count;
  assign if_le.in_data = in_data;       assign if_be.in_data = in_data;
  assign if_le.in_valid = in_valid;     assign if_be.in_valid = in_valid;
  assign if_le.out_ready = out_ready;   assign if_be.out_ready = out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAMs with a backdoor write port for preloading.
  always @(posedge clk) begin
    if (bd_we) begin
      ram_le[bd_a] <= bd_d;
      ram_be[bd_a] <= bd_d;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (if_le.mem_we && if_le.mem_be[l]) ram_le[if_le.mem_addr][8*l +: 8] <= if_le.mem_wdata[8*l +: 8];
        if (if_be.mem_we && if_be.mem_be[l]) ram_be[if_be.mem_addr][8*l +: 8] <= if_be.mem_wdata[8*l +: 8];
      end
    end
    if_le.mem_rdata <= ram_le[if_le.mem_addr];
    if_be.mem_rdata <= ram_be[if_be.mem_addr];
  end

  always @(negedge clk) begin
    if (if_le.mem_we) wr_le.push_back({if_le.mem_addr, if_le.mem_be, if_le.mem_wdata});
    if (if_be.mem_we) wr_be.push_back({if_be.mem_addr, if_be.mem_be, if_be.mem_wdata});
    if (if_le.out_valid && out_ready) rd_le.push_back(if_le.out_data);
    if (if_be.out_valid && out_ready) rd_be.push_back(if_be.out_data);
    if (if_le.done) done_le++;
    if (if_be.done) done_be++;
    if (if_le.out_valid && first_ov < 0) first_ov = cyc;
    if ((if_le.in_ready && cur_mode) || (if_le.out_valid && !cur_mode) || (if_le.mem_we && cur_mode)) viol_le++;
    if ((if_be.in_ready && cur_mode) || (if_be.out_valid && !cur_mode) || (if_be.mem_we && cur_mode)) viol_be++;
    if (prev_stall_le && (!if_le.out_valid || if_le.out_data != prev_data_le)) viol_le++;
    if (prev_stall_be && (!if_be.out_valid || if_be.out_data != prev_data_be)) viol_be++;
    if ({if_le.busy, if_le.done, if_le.in_ready, if_le.out_valid, if_le.mem_we, if_le.mem_addr} !=
        {if_be.busy, if_be.done, if_be.in_ready, if_be.out_valid, if_be.mem_we, if_be.mem_addr}) viol_be++;
    prev_stall_le = if_le.out_valid && !out_ready;
    prev_stall_be = if_be.out_valid && !out_ready;
    prev_data_le  = if_le.out_data;
    prev_data_be  = if_be.out_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    bd_a  = 4'(a);
    bd_d  = d;
    bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    mdl_le[a] = d;
    mdl_be[a] = d;
  endtask

  task automatic drive_bytes(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = tx_bytes[i];
      t = 0;
      @(negedge clk);
      while (!if_le.in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!if_le.in_ready) begin
        check("in_ready_timeout", if_le.in_ready, 1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Expected word writes come straight from byte index -> (word, lane).
  task automatic check_writes(input bit e, input int sw, input int eff);
    wr_t got[$];
    int nw, ea, ln;
    logic [31:0] ed;
    logic [3:0]  eb;
    string sfx;
    sfx = e ? "be" : "le";
    got = e ? wr_be : wr_le;
    nw = (eff + 3) / 4;
    check($sformatf("wr_count_%s", sfx), got.size(), nw);
    for (int w = 0; w < nw; w++) begin
      ed = '0;
      eb = '0;
      for (int i = w * 4; i < eff && i < w * 4 + 4; i++) begin
        ln = e ? 3 - (i % 4) : i % 4;
        ed = ed | (32'(tx_bytes[i]) << (8 * ln));
        eb[ln] = 1'b1;
      end
      ea = (sw + w) % 16;
      if (w < got.size()) begin
        check($sformatf("wr%0d_addr_%s", w, sfx), got[w].a, ea);
        check($sformatf("wr%0d_be_%s", w, sfx), got[w].be, eb);
        check($sformatf("wr%0d_data_%s", w, sfx), got[w].d, ed);
      end
      for (int l = 0; l < 4; l++) begin
        if (eb[l]) begin
          if (e) mdl_be[ea][8*l +: 8] = ed[8*l +: 8];
          else   mdl_le[ea][8*l +: 8] = ed[8*l +: 8];
        end
      end
    end
  endtask

  task automatic check_reads(input bit e, input int sw, input int eff);
    logic [7:0] got[$];
    logic [31:0] w;
    int ln;
    string sfx;
    sfx = e ? "be" : "le";
    got = e ? rd_be : rd_le;
    check($sformatf("rd_count_%s", sfx), got.size(), eff);
    for (int i = 0; i < eff && i < got.size(); i++) begin
      w  = e ? mdl_be[(sw + i / 4) % 16] : mdl_le[(sw + i / 4) % 16];
      ln = e ? 3 - (i % 4) : i % 4;
      check($sformatf("rd%0d_%s", i, sfx), got[i], w[8*ln +: 8]);
    end
  endtask

  task automatic clear_mon(input bit md);
    wr_le.delete(); wr_be.delete(); rd_le.delete(); rd_be.delete();
    done_le = 0; done_be = 0; viol_le = 0; viol_be = 0;
    first_ov = -1;
    cur_mode = md;
  endtask

  task automatic xfer(input bit md, input int sw, input int cnt, input bit stall, input bit restart);
    int eff;
    int t;
    eff = (cnt > 64) ? 64 : cnt;
    if (!md) while (tx_bytes.size() < eff) tx_bytes.push_back(8'($urandom));
    clear_mon(md);
    out_ready = stall ? 1'($urandom) : 1'b1;
    @(posedge clk); #1;
    start = 1'b1; mode = md; start_word = 4'(sw); byte_count = 7'(cnt);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom);
    if (cnt == 0) check("zero_count_done", if_le.done, 1);
    else          check("busy_after_start", if_le.busy, 1);
    fork
      begin
        if (!md) drive_bytes(eff);
      end
      begin
        if (restart) begin
          repeat (4) @(posedge clk);
          #1;
          start = 1'b1; mode = 1'b1; start_word = 4'(sw + 7); byte_count = 7'd3;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    for (t = 0; t < 1000 && done_le == 0; t++) begin
      @(posedge clk); #1;
      out_ready = stall ? 1'($urandom) : 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses_le", done_le, 1);
    check("done_pulses_be", done_be, 1);
    check("protocol_le", viol_le, 0);
    check("protocol_be", viol_be, 0);
    check("busy_idle", if_le.busy, 0);
    if (md && eff > 0) check("read_latency", first_ov - start_cyc, 3);
    if (!md) begin
      check_writes(1'b0, sw, eff);
      check_writes(1'b1, sw, eff);
    end else begin
      check_reads(1'b0, sw, eff);
      check_reads(1'b1, sw, eff);
    end
    tx_bytes.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp3 [5];
    exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    n_checks = 0; n_pass = 0; cyc = 0; first_ov = -1;
    start = 0; mode = 0; start_word = 0; byte_count = 0;
    in_data = 0; in_valid = 0; out_ready = 0; bd_we = 0; bd_a = 0; bd_d = 0;
    gaps = 0; cur_mode = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl_le", {if_le.busy, if_le.done, if_le.in_ready, if_le.out_valid, if_le.mem_we,
                            if_le.mem_be, if_le.mem_addr, if_le.out_data}, 0);
    check("reset_ctrl_be", {if_be.busy, if_be.done, if_be.in_ready, if_be.out_valid, if_be.mem_we,
                            if_be.mem_be, if_be.mem_addr, if_be.out_data}, 0);
    check("reset_wdata_le", if_le.mem_wdata, 0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) poke(a, $urandom);

    tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    xfer(1'b0, 0, 8, 1'b0, 1'b0);
    if (wr_le.size() >= 2) begin
      check("le8_w0", {wr_le[0].a, wr_le[0].be, wr_le[0].d}, {4'd0, 4'hF, 32'h04030201});
      check("le8_w1", {wr_le[1].a, wr_le[1].be, wr_le[1].d}, {4'd1, 4'hF, 32'h08070605});
    end

    tx_bytes = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
    xfer(1'b0, 0, 6, 1'b0, 1'b0);
    if (wr_be.size() >= 2) begin
      check("be6_w0", {wr_be[0].a, wr_be[0].be, wr_be[0].d}, {4'd0, 4'hF, 32'hAAABACAD});
      check("be6_w1", {wr_be[1].a, wr_be[1].be, wr_be[1].d}, {4'd1, 4'hC, 32'hAEAF0000});
    end

    poke(15, 32'h44332211);
    poke(0, 32'h88776655);
    xfer(1'b1, 15, 5, 1'b1, 1'b0);
    for (int i = 0; i < 5 && i < rd_le.size(); i++) check($sformatf("wrap_rd%0d", i), rd_le[i], exp3[i]);

    xfer(1'b0, 3, 0, 1'b0, 1'b0);
    xfer(1'b1, 7, 0, 1'b0, 1'b0);

    // Reset in the middle of a write.
    clear_mon(1'b0);
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'($urandom));
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; start_word = 4'd9; byte_count = 7'd8;
    @(posedge clk); #1;
    start = 1'b0;
    drive_bytes(3);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl_le", {if_le.busy, if_le.done, if_le.in_ready, if_le.out_valid, if_le.mem_we,
                             if_le.mem_be, if_le.mem_addr, if_le.out_data}, 0);
    check("midrst_ctrl_be", {if_be.busy, if_be.done, if_be.in_ready, if_be.out_valid, if_be.mem_we,
                             if_be.mem_be, if_be.mem_addr, if_be.out_data}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {if_le.busy, if_le.in_ready, if_be.busy, if_be.in_ready}, 0);
    check("post_rst_no_we_le", wr_le.size(), 0);
    check("post_rst_no_we_be", wr_be.size(), 0);
    tx_bytes.delete();

    gaps = 1'b0;
    xfer(1'b0, 5, 10, 1'b0, 1'b1);
    xfer(1'b1, 5, 10, 1'b1, 1'b0);

    gaps = 1'b1;
    xfer(1'b0, 2, 100, 1'b1, 1'b0);
    xfer(1'b1, 0, 127, 1'b1, 1'b0);

    for (int k = 0; k < 14; k++) begin
      gaps = 1'($urandom);
      xfer(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 70), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
